// File: rtl/module_control_calcu.sv
// Keypad-entry controller for the calculator ALU: builds decimal operands A/B and
// the opcode from key pulses, captures the ALU result on "=", and drives the display.
module module_control_calcu #(
  parameter int MAX_DIGITS = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        key_valid_i,
  input  logic [3:0]  key_code_i,
  input  logic [15:0] result_i,
  output logic [15:0] operador_a_o,
  output logic [15:0] operador_b_o,
  output logic [3:0]  operando_o,
  output logic [15:0] display_o,
  output logic [1:0]  state_o,
  output logic        done_o
);

  // state    | meaning
  // ENTER_A  | collecting digits of operand A
  // ENTER_B  | operator latched, collecting digits of operand B
  // CALC     | one-cycle wait while the ALU settles
  // RESULT   | result captured; digit restarts, operator chains
  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    CALC    = 2'd2,
    RESULT  = 2'd3
  } state_t;

  localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

  state_t      r_state;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [15:0] r_res;
  logic [3:0]  r_op;
  logic [2:0]  r_cnt_a;
  logic [2:0]  r_cnt_b;
  logic        r_done;

  logic        w_is_digit;
  logic        w_is_eq;
  logic        w_is_op;
  logic [15:0] w_digit;
  logic [15:0] w_a_app;
  logic [15:0] w_b_app;
  logic        w_a_room;
  logic        w_b_room;

  assign w_is_digit = (key_code_i <= 4'd9);
  assign w_is_eq    = (key_code_i == 4'hF);
  assign w_is_op    = !w_is_digit && !w_is_eq;
  assign w_digit    = {12'd0, key_code_i};
  assign w_a_app    = r_a * 16'd10 + w_digit;
  assign w_b_app    = r_b * 16'd10 + w_digit;
  assign w_a_room   = (r_cnt_a < MAX_CNT);
  assign w_b_room   = (r_cnt_b < MAX_CNT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ENTER_A;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_op    <= '0;
      r_cnt_a <= '0;
      r_cnt_b <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ENTER_A: begin
          if (key_valid_i) begin
            if (w_is_digit && w_a_room) begin
              r_a     <= w_a_app;
              r_cnt_a <= r_cnt_a + 3'd1;
            end else if (w_is_op) begin
              r_op    <= key_code_i;
              r_b     <= '0;
              r_cnt_b <= '0;
              r_state <= ENTER_B;
            end
          end
        end
        ENTER_B: begin
          if (key_valid_i) begin
            if (w_is_digit && w_b_room) begin
              r_b     <= w_b_app;
              r_cnt_b <= r_cnt_b + 3'd1;
            end else if (w_is_eq) begin
              r_state <= CALC;
            end else if (w_is_op && (r_cnt_b == 3'd0)) begin
              r_op <= key_code_i;
            end
          end
        end
        CALC: begin
          r_res   <= result_i;
          r_done  <= 1'b1;
          r_state <= RESULT;
        end
        RESULT: begin
          if (key_valid_i) begin
            if (w_is_digit) begin
              r_a     <= w_digit;
              r_cnt_a <= 3'd1;
              r_b     <= '0;
              r_cnt_b <= '0;
              r_op    <= '0;
              r_state <= ENTER_A;
            end else if (w_is_op) begin
              // chained result is treated as a full operand so it cannot be extended
              r_a     <= r_res;
              r_cnt_a <= MAX_CNT;
              r_op    <= key_code_i;
              r_b     <= '0;
              r_cnt_b <= '0;
              r_state <= ENTER_B;
            end
          end
        end
        default: r_state <= ENTER_A;
      endcase
    end
  end

  always_comb begin
    display_o = r_a;
    case (r_state)
      ENTER_A: display_o = r_a;
      ENTER_B: display_o = (r_cnt_b != 3'd0) ? r_b : r_a;
      CALC:    display_o = r_a;
      RESULT:  display_o = r_res;
      default: display_o = r_a;
    endcase
  end

  assign operador_a_o = r_a;
  assign operador_b_o = r_b;
  assign operando_o   = r_op;
  assign state_o      = r_state;
  assign done_o       = r_done;

endmodule

// File: doc/module_control_calcu.md
Name: module_control_calcu

Overview:
Keypad-entry controller that sits directly upstream of the calculator ALU. It accepts one decoded key per pulse, builds decimal operand A, the operator code and decimal operand B, and drives them to the ALU operand and opcode inputs. On "=" it captures the ALU's combinational result, and it supplies the value shown on the display. It supports chaining, so a result can become the next operand A.

Parameters:
MAX_DIGITS, 4, maximum decimal digits per operand; legal range 1..4 so that 9999 fits in 16 bits.

Ports:
clk_i  input  1  system clock; all logic is rising-edge.
rst_i  input  1  synchronous, active-high reset.
key_valid_i  input  1  one-cycle strobe; key_code_i is valid when this is high.
key_code_i  input  4  4'h0-4'h9 digit; 4'hA add; 4'hB sub; 4'hC or; 4'hD and; 4'hE shift right; 4'hF equals.
result_i  input  16  combinational result returned by the ALU.
operador_a_o  output  16  operand A register, to the ALU.
operador_b_o  output  16  operand B register, to the ALU.
operando_o  output  4  opcode register, to the ALU.
display_o  output  16  binary value to display.
state_o  output  2  current state: 0 ENTER_A, 1 ENTER_B, 2 CALC, 3 RESULT.
done_o  output  1  one-cycle pulse when the result register is loaded.

Behaviour:
- Reset (rst_i high at a clock edge):
  - State = ENTER_A.
  - A, B and result registers = 0; opcode = 4'b0000 (the ALU outputs 0 for this code).
  - Digit counters = 0; done_o = 0.
  - Reset wins over any key that arrives in the same cycle.
  - Reset mid-operation, including in CALC, aborts without capturing a result.
- Keys are acted on only on clock edges where key_valid_i = 1. At most one key is accepted per cycle.
- Digit append: reg <= reg*10 + digit, computed in 16 bits, and the counter increments.
  - A digit is ignored when the counter equals MAX_DIGITS.
  - A leading 0 does increment the counter.
- ENTER_A:
  - Digit: append to A.
  - Operator (A-E): latch opcode, clear B and its counter, go to ENTER_B. If no digits were entered, A stays 0.
  - "=": ignored.
- ENTER_B:
  - Digit: append to B.
  - Operator while the B counter = 0: replace the opcode and stay in ENTER_B.
  - Operator while the B counter > 0: ignored.
  - "=": go to CALC. If no B digits were entered, B = 0.
- CALC:
  - Lasts exactly one cycle; the ALU settles combinationally during it.
  - At the next edge: result register <= result_i, done_o = 1 for that one cycle, go to RESULT.
  - Keys arriving during CALC are dropped.
- RESULT:
  - Digit: A <= digit, A counter = 1, B = 0, opcode = 0, go to ENTER_A.
  - Operator: A <= result register, A counter = MAX_DIGITS (blocks appending), latch opcode, B = 0, go to ENTER_B.
  - "=": ignored; the result is not recomputed.
- display_o:
  - ENTER_A: A.
  - ENTER_B: B if the B counter > 0, otherwise A.
  - CALC: A.
  - RESULT: result register.
  - Value after reset: 0.
- Latency: "=" accepted at edge n; state is CALC after edge n; result is captured and done_o is high after edge n+1.
- Arithmetic wrap is owned by the ALU; the 16-bit two's-complement wrap of subtraction is passed through unchanged.
- Operand outputs are registered and hold their value between keys.

Test Plan:
- Reset, then keys 1,2,A,3,4,F → operador_a_o = 12, operador_b_o = 34, operando_o = 4'hA; state goes CALC then RESULT; done_o pulses once; display_o = 46.
- Keys 5,B,7,F → result wraps to 16'hFFFE; display_o = 16'hFFFE.
- Keys 1,2,3,4,5 → A = 1234 (5th digit ignored); then A,B → operando_o = 4'hB (replaced); then 1,F → result 1233.
- After a result of 46: keys C,1,F → A = 46, B = 1, result 47. Then key 9 → state ENTER_A, A = 9, display_o = 9.
- Assert rst_i on the same edge as key_valid_i with key 4'hF while in ENTER_B, and separately during CALC → all outputs reset; no done_o pulse.
- Key pulse during CALC, and "=" in ENTER_A or RESULT → no state change and no register change.
